nvram_restore: RTL and testbench
================================

// Module: nvram_restore
// PURPOSE
//  Receive side of the hiscore/NVRAM path. Consumes the HPS ioctl download stream
//  for the NVRAM index, pauses the CPU, and writes each byte into the game CMOS RAM
//  port. Sits beside the nvram dump block in emu; its outputs are muxed onto dn_addr/dn_din/dn_nvram_wr.
// PARAMETERS
//  DUMPWIDTH  8  NVRAM address bits; image size = 2**DUMPWIDTH bytes
//  DUMPINDEX  4  ioctl_index value selecting the NVRAM image
//  PAUSEPAD   2  idle cycles after pause ack before first write, and after last write before unpause
// PORTS
//  clk             in   1          system clock (clk_sys)
//  reset           in   1          synchronous, active-high reset
//  ioctl_download  in   1          HPS download active
//  ioctl_index     in   8          image index
//  ioctl_wr        in   1          1-cycle strobe: ioctl_addr/ioctl_dout valid
//  ioctl_addr      in   25         byte address
//  ioctl_dout      in   8          byte data
//  ioctl_wait      out  1          backpressure to HPS; while high no ioctl_wr arrives
//  paused          in   1          CPU is halted (from pause block)
//  pause_cpu       out  1          pause request
//  nvram_address   out  DUMPWIDTH  CMOS RAM write address
//  nvram_data_out  out  8          CMOS RAM write data
//  nvram_we        out  1          1-cycle write strobe
//  loaded          out  1          sticky: at least one complete image restored
//  overflow        out  1          sticky: a byte with ioctl_addr >= 2**DUMPWIDTH was dropped
// BEHAVIOUR
//  - sel = ioctl_download & (ioctl_index == DUMPINDEX).
//  - Reset: state IDLE; ioctl_wait, pause_cpu, nvram_we, loaded, overflow = 0; address/data = 0.
//  - FSM: IDLE -> REQ (sel rises): pause_cpu=1, ioctl_wait=1 same registered cycle.
//    REQ -> PADIN when paused=1. PADIN counts PAUSEPAD cycles -> RECV, ioctl_wait=0.
//    RECV: each ioctl_wr with ioctl_addr[24:DUMPWIDTH]==0 -> next cycle nvram_we=1,
//    nvram_address=ioctl_addr[DUMPWIDTH-1:0], nvram_data_out=ioctl_dout. Latency 1 clk.
//    Out-of-range ioctl_wr: no nvram_we, overflow<=1. Back-to-back ioctl_wr accepted every cycle.
//    RECV -> PADOUT when sel falls (ioctl_wr in that same cycle is still written).
//    PADOUT counts PAUSEPAD cycles -> IDLE with pause_cpu=0; loaded<=1 iff >=1 byte written.
//  - pause_cpu held 1 from REQ through end of PADOUT; released only in IDLE.
//  - If paused drops during RECV, ioctl_wait=1 until paused returns; writes issued meanwhile are
//    impossible (no ioctl_wr while waiting).
//  - sel falling while in REQ/PADIN: go straight to PADOUT; loaded unchanged.
//  - ioctl_index change mid-download treated as sel falling.
//  - Duplicate addresses: last write wins (no dedupe). Address order arbitrary.
//  - Download of other indexes ignored entirely; ioctl_wait stays 0.
//  - Reset mid-operation: immediate IDLE, pause_cpu=0, ioctl_wait=0, in-flight write dropped.
//  - PAUSEPAD=0: PADIN/PADOUT last zero cycles (transition same edge).
// TESTING
//  1 DUMPWIDTH=8: download idx4, paused acks after 5 clk, 256 bytes data=addr^8'hA5 -> RAM
//    model matches, first nvram_we >= PAUSEPAD+1 clk after paused, loaded=1, pause_cpu=0 after +2 clk.
//  2 Download idx0 (ROM) of 1000 bytes -> no nvram_we, pause_cpu/ioctl_wait stay 0.
//  3 ioctl_addr=0x100 data 0x77 in image -> dropped, overflow=1, other bytes written.
//  4 Back-to-back ioctl_wr at 0x10,0x11,0x12 -> three consecutive nvram_we cycles, 1-clk latency.
//  5 reset asserted mid-RECV after 40 bytes -> next clk pause_cpu=0, ioctl_wait=0, no further writes.
//  6 sel drops while waiting for paused -> PADOUT, pause released after PAUSEPAD, loaded=0.

Source files
------------

// File: rtl/nvram_restore.sv
// NVRAM restore: takes the HPS ioctl download for the NVRAM index, holds the CPU paused,
// and copies each byte into the CMOS RAM write port.
module nvram_restore #(
  parameter int DUMPWIDTH = 8,
  parameter int DUMPINDEX = 4,
  parameter int PAUSEPAD  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic                 ioctl_wait,
  input  logic                 paused,
  output logic                 pause_cpu,
  output logic [DUMPWIDTH-1:0] nvram_address,
  output logic [7:0]           nvram_data_out,
  output logic                 nvram_we,
  output logic                 loaded,
  output logic                 overflow
);

  localparam int CW = (PAUSEPAD > 1) ? $clog2(PAUSEPAD) : 1;
  localparam logic [CW-1:0] PADLAST = CW'((PAUSEPAD > 0) ? PAUSEPAD - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_PADIN, S_RECV, S_PADOUT} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wait_q, wait_d;
  logic                 pause_q, pause_d;
  logic                 we_q, we_d;
  logic [DUMPWIDTH-1:0] addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic                 loaded_q, loaded_d;
  logic                 ovf_q, ovf_d;
  logic                 wrote_q, wrote_d;
  logic                 sel, in_range, start_out, done;

  assign sel      = ioctl_download && (ioctl_index == 8'(DUMPINDEX));
  assign in_range = (ioctl_addr[24:DUMPWIDTH] == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    pause_d   = pause_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    loaded_d  = loaded_q;
    ovf_d     = ovf_q;
    wrote_d   = wrote_q;
    start_out = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        wait_d  = 1'b0;
        pause_d = 1'b0;
        if (sel) begin
          state_d = S_REQ;
          pause_d = 1'b1;
          wait_d  = 1'b1;
          wrote_d = 1'b0;
        end
      end
      S_REQ: begin
        if (!sel) start_out = 1'b1;
        else if (paused) begin
          if (PAUSEPAD == 0) begin
            state_d = S_RECV;
            wait_d  = 1'b0;
          end else begin
            state_d = S_PADIN;
            cnt_d   = '0;
          end
        end
      end
      S_PADIN: begin
        if (!sel) start_out = 1'b1;
        else if (cnt_q == PADLAST) begin
          state_d = S_RECV;
          wait_d  = 1'b0;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_RECV: begin
        // a strobe in the same cycle sel falls is still honoured
        if (ioctl_wr) begin
          if (in_range) begin
            we_d    = 1'b1;
            addr_d  = ioctl_addr[DUMPWIDTH-1:0];
            data_d  = ioctl_dout;
            wrote_d = 1'b1;
          end else ovf_d = 1'b1;
        end
        if (!sel) start_out = 1'b1;
        else wait_d = !paused;
      end
      S_PADOUT: begin
        if (cnt_q == PADLAST) done = 1'b1;
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (start_out) begin
      wait_d = 1'b0;
      if (PAUSEPAD == 0) done = 1'b1;
      else begin
        state_d = S_PADOUT;
        cnt_d   = '0;
      end
    end
    if (done) begin
      state_d = S_IDLE;
      pause_d = 1'b0;
      if (wrote_d) loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wait_q   <= 1'b0;
      pause_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      loaded_q <= 1'b0;
      ovf_q    <= 1'b0;
      wrote_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      pause_q  <= pause_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      loaded_q <= loaded_d;
      ovf_q    <= ovf_d;
      wrote_q  <= wrote_d;
    end
  end

  assign ioctl_wait     = wait_q;
  assign pause_cpu      = pause_q;
  assign nvram_we       = we_q;
  assign nvram_address  = addr_q;
  assign nvram_data_out = data_q;
  assign loaded         = loaded_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_nvram_restore.sv
// Bench for nvram_restore: scoreboard of expected CMOS writes (address, data, cycle) checked as they appear.
module tb_nvram_restore;
  localparam int PP = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic        ioctl_download = 1'b0, ioctl_wr = 1'b0, paused = 1'b0;
  logic [7:0]  ioctl_index = 8'd0, ioctl_dout = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic        ioctl_wait, pause_cpu, nvram_we, loaded, overflow;
  logic [7:0]  nvram_address, nvram_data_out;

  nvram_restore #(.DUMPWIDTH(8), .DUMPINDEX(4), .PAUSEPAD(PP)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .paused(paused), .pause_cpu(pause_cpu), .nvram_address(nvram_address),
    .nvram_data_out(nvram_data_out), .nvram_we(nvram_we), .loaded(loaded), .overflow(overflow));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] a; logic [7:0] d; int c; } exp_t;
  exp_t sbq[$];
  exp_t me;
  int   we_log[$];
  logic [7:0] exp_ram [256];
  logic [7:0] dut_ram [256];
  int passed = 0, total = 0;

  // every write the DUT issues must match the head of the scoreboard, including its cycle
  always @(negedge clk) if (nvram_we === 1'b1) begin
    we_log.push_back(cyc);
    dut_ram[nvram_address] = nvram_data_out;
    total++;
    if (sbq.size() == 0)
      $display("FAIL unexpected_we got addr=%h data=%h required no write", nvram_address, nvram_data_out);
    else begin
      me = sbq.pop_front();
      if (nvram_address !== me.a || nvram_data_out !== me.d || cyc !== me.c)
        $display("FAIL write got a=%h d=%h cyc=%0d required a=%h d=%h cyc=%0d",
                 nvram_address, nvram_data_out, cyc, me.a, me.d, me.c);
      else passed++;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    if (ioctl_download && ioctl_index == 8'd4 && a < 25'd256) begin
      sbq.push_back('{a[7:0], d, cyc + 1});
      exp_ram[a[7:0]] = d;
    end
    tick;
    ioctl_wr = 1'b0;
  endtask

  // raise the NVRAM download; optionally ack pause 5 clk later and wait for the window to open
  task automatic open_img(input bit ack, output logic p0, output logic w0, output int ackc, output bit ok);
    ok = 1'b1; ackc = 0;
    ioctl_index = 8'd4; ioctl_download = 1'b1;
    tick;
    @(negedge clk);
    p0 = pause_cpu; w0 = ioctl_wait;
    if (ack) begin
      repeat (5) @(posedge clk);
      #1 paused = 1'b1; ackc = cyc;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        if (ioctl_wait === 1'b0) ok = 1'b1;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    @(negedge clk);
    total++;
    if ({ioctl_wait, pause_cpu, nvram_we, loaded, overflow, nvram_address, nvram_data_out} !== 21'd0)
      $display("FAIL reset_state got w=%b p=%b we=%b ld=%b ov=%b a=%h d=%h required all 0",
               ioctl_wait, pause_cpu, nvram_we, loaded, overflow, nvram_address, nvram_data_out);
    else passed++;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_full_image;
    logic p0, w0; int ackc; bit ok; int errs;
    we_log.delete();
    open_img(1'b1, p0, w0, ackc, ok);
    total++;
    if (p0 !== 1'b1 || w0 !== 1'b1) $display("FAIL req_outputs got p=%b w=%b required 1 1", p0, w0);
    else passed++;
    total++;
    if (!ok) $display("FAIL padin_timeout got wait stuck high required low within 50 clk");
    else passed++;
    for (int i = 0; i < 256; i++) wr_byte(25'(i), 8'(i) ^ 8'hA5);
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (pause_cpu !== 1'b1) $display("FAIL padout_hold got pause=%b required 1", pause_cpu);
    else passed++;
    @(posedge clk); @(negedge clk);
    total++;
    if (pause_cpu !== 1'b0 || loaded !== 1'b1)
      $display("FAIL full_release got pause=%b loaded=%b required 0 1", pause_cpu, loaded);
    else passed++;
    total++;
    if (we_log.size() == 0 || we_log[0] - ackc < PP + 1)
      $display("FAIL first_we_latency got %0d required >= %0d", (we_log.size() > 0) ? we_log[0] - ackc : -1, PP + 1);
    else passed++;
    errs = 0;
    for (int i = 0; i < 256; i++) if (dut_ram[i] !== exp_ram[i]) errs++;
    total++;
    if (errs != 0 || sbq.size() != 0)
      $display("FAIL ram_image got %0d bad bytes, %0d pending required 0 0", errs, sbq.size());
    else passed++;
    paused = 1'b0;
    tick;
  endtask

  task automatic test_other_index;
    int bad = 0;
    we_log.delete();
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick;
    for (int i = 0; i < 1000; i++) begin
      wr_byte(25'(i), 8'(i));
      if (pause_cpu !== 1'b0 || ioctl_wait !== 1'b0) bad++;
    end
    ioctl_download = 1'b0;
    repeat (3) tick;
    total++;
    if (bad != 0 || we_log.size() != 0 || overflow !== 1'b0)
      $display("FAIL rom_ignored got bad=%0d writes=%0d ov=%b required 0 0 0", bad, we_log.size(), overflow);
    else passed++;
  endtask

  task automatic test_overflow;
    logic p0, w0; int ackc; bit ok;
    we_log.delete();
    open_img(1'b1, p0, w0, ackc, ok);
    wr_byte(25'h20, 8'h11);
    wr_byte(25'h100, 8'h77);
    wr_byte(25'h21, 8'h22);
    wr_byte(25'h1FFFF, 8'h33);
    ioctl_download = 1'b0;
    repeat (4) tick;
    paused = 1'b0;
    @(negedge clk);
    total++;
    if (overflow !== 1'b1 || we_log.size() != 2 || sbq.size() != 0 || pause_cpu !== 1'b0)
      $display("FAIL overflow got ov=%b writes=%0d pending=%0d pause=%b required 1 2 0 0",
               overflow, we_log.size(), sbq.size(), pause_cpu);
    else passed++;
    tick;
  endtask

  task automatic test_back_to_back;
    logic p0, w0; int ackc; bit ok;
    we_log.delete();
    open_img(1'b1, p0, w0, ackc, ok);
    wr_byte(25'h10, 8'hC0);
    wr_byte(25'h11, 8'hC1);
    wr_byte(25'h12, 8'hC2);
    ioctl_download = 1'b0;
    repeat (4) tick;
    paused = 1'b0;
    total++;
    if (we_log.size() != 3 || we_log[1] != we_log[0] + 1 || we_log[2] != we_log[1] + 1)
      $display("FAIL back_to_back got %0d writes non-consecutive required 3 consecutive", we_log.size());
    else passed++;
    tick;
  endtask

  task automatic test_reset_mid;
    logic p0, w0; int ackc; bit ok;
    we_log.delete();
    open_img(1'b1, p0, w0, ackc, ok);
    for (int i = 0; i < 40; i++) wr_byte(25'(i + 64), 8'(i));
    ioctl_wr = 1'b1; ioctl_addr = 25'd50; ioctl_dout = 8'hEE;
    reset = 1'b1; ioctl_download = 1'b0;
    tick;
    ioctl_wr = 1'b0;
    @(negedge clk);
    total++;
    if (pause_cpu !== 1'b0 || ioctl_wait !== 1'b0 || nvram_we !== 1'b0 || loaded !== 1'b0)
      $display("FAIL reset_mid got p=%b w=%b we=%b ld=%b required 0 0 0 0", pause_cpu, ioctl_wait, nvram_we, loaded);
    else passed++;
    paused = 1'b0;
    tick;
    reset = 1'b0;
    repeat (10) tick;
    total++;
    if (we_log.size() != 40 || sbq.size() != 0)
      $display("FAIL reset_drop got writes=%0d pending=%0d required 40 0", we_log.size(), sbq.size());
    else passed++;
  endtask

  task automatic test_sel_drop;
    logic p0, w0; int ackc; bit ok;
    open_img(1'b0, p0, w0, ackc, ok);
    total++;
    if (p0 !== 1'b1 || w0 !== 1'b1) $display("FAIL drop_req got p=%b w=%b required 1 1", p0, w0);
    else passed++;
    repeat (3) tick;
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (pause_cpu !== 1'b1 || ioctl_wait !== 1'b0)
      $display("FAIL drop_padout got p=%b w=%b required 1 0", pause_cpu, ioctl_wait);
    else passed++;
    @(posedge clk); @(negedge clk);
    total++;
    if (pause_cpu !== 1'b0 || loaded !== 1'b0 || ioctl_wait !== 1'b0)
      $display("FAIL drop_release got p=%b ld=%b w=%b required 0 0 0", pause_cpu, loaded, ioctl_wait);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_full_image;
    test_other_index;
    test_overflow;
    test_back_to_back;
    test_reset_mid;
    test_sel_drop;
    repeat (3) tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
